// File: rtl/io_uart_in.sv
// io_uart_in: 8N1 UART receiver with receive FIFO.
// Read/write registers on the io bus, rdata daisy chain.
module io_uart_in #(
  parameter int          FIFO_DEPTH = 16,
  parameter logic [15:0] DIV_RESET  = 16'd434,
  parameter logic [13:0] BASE_ADR   = 14'h3F10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_in,
  input  logic        dma_io_we,
  input  logic [13:0] dma_io_wadr,
  input  logic [31:0] dma_io_wdata,
  input  logic [13:0] dma_io_radr,
  input  logic        dma_io_radr_en,
  input  logic [31:0] dma_io_rdata_in,
  output logic [31:0] dma_io_rdata,
  output logic        ext_uart_rx_interrupt_1shot
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t      r_state;
  state_t      w_state_nx;
  logic        r_rx_s1;
  logic        r_rx_s2;
  logic        r_rx_prev;
  logic [15:0] r_smp;
  logic [15:0] w_smp_nx;
  logic [2:0]  r_bit;
  logic [2:0]  w_bit_nx;
  logic [7:0]  r_shift;
  logic [7:0]  w_shift_nx;
  logic        w_push;
  logic        w_ferr_set;
  logic        w_fall;

  logic        r_en;
  logic        r_irq_en;
  logic        r_ovr;
  logic        r_ferr;
  logic [15:0] r_div;
  logic        r_irq;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_cnt;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push_ok;
  logic          w_ovr_set;

  logic        w_rd_rx;
  logic        w_wr_ctrl;
  logic        w_wr_div;
  logic [15:0] w_div_wr;
  logic [13:0] w_roff;
  logic        w_rsel;
  logic [31:0] w_rval;
  logic [4:0]  w_cnt5;
  logic        r_hit;
  logic [31:0] r_rdata;

  assign w_fall = r_rx_prev & ~r_rx_s2;

  // two-flop synchroniser plus previous value for edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_s1   <= 1'b1;
      r_rx_s2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_s1   <= rx_in;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
    end
  end

  // receiver FSM state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_smp   <= 16'd0;
      r_bit   <= 3'd0;
      r_shift <= 8'd0;
    end else begin
      r_state <= w_state_nx;
      r_smp   <= w_smp_nx;
      r_bit   <= w_bit_nx;
      r_shift <= w_shift_nx;
    end
  end

  // next state: sample at counter zero, reload with DIV-1
  always_comb begin
    w_state_nx = r_state;
    w_smp_nx   = r_smp;
    w_bit_nx   = r_bit;
    w_shift_nx = r_shift;
    w_push     = 1'b0;
    w_ferr_set = 1'b0;
    if (!r_en) begin
      w_state_nx = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_fall) begin
            w_state_nx = S_START;
            w_smp_nx   = r_div >> 1;
            w_bit_nx   = 3'd0;
          end
        end
        S_START: begin
          if (r_smp == 16'd0) begin
            if (!r_rx_s2) begin
              w_state_nx = S_DATA;
              w_smp_nx   = r_div - 16'd1;
            end else begin
              w_state_nx = S_IDLE;
            end
          end else begin
            w_smp_nx = r_smp - 16'd1;
          end
        end
        S_DATA: begin
          if (r_smp == 16'd0) begin
            w_shift_nx = {r_rx_s2, r_shift[7:1]};
            w_bit_nx   = r_bit + 3'd1;
            w_smp_nx   = r_div - 16'd1;
            if (r_bit == 3'd7) w_state_nx = S_STOP;
          end else begin
            w_smp_nx = r_smp - 16'd1;
          end
        end
        S_STOP: begin
          if (r_smp == 16'd0) begin
            w_state_nx = S_IDLE;
            w_push     = r_rx_s2;
            w_ferr_set = ~r_rx_s2;
          end else begin
            w_smp_nx = r_smp - 16'd1;
          end
        end
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  assign w_rd_rx   = dma_io_radr_en && (dma_io_radr == BASE_ADR);
  assign w_wr_ctrl = dma_io_we && (dma_io_wadr == BASE_ADR + 14'd2);
  assign w_wr_div  = dma_io_we && (dma_io_wadr == BASE_ADR + 14'd3);
  assign w_div_wr  = (dma_io_wdata[15:0] < 16'd16) ?
                     16'd16 : dma_io_wdata[15:0];

  assign w_empty   = (r_cnt == '0);
  assign w_full    = (r_cnt == DEPTH_C);
  assign w_pop     = w_rd_rx & ~w_empty;
  // a pop in the same cycle frees the slot a full FIFO needs
  assign w_push_ok = w_push & (~w_full | w_pop);
  assign w_ovr_set = w_push & w_full & ~w_pop;

  // FIFO storage
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wp] <= r_shift;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push_ok) r_wp <= r_wp + 1'b1;
      if (w_pop)     r_rp <= r_rp + 1'b1;
      if (w_push_ok && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (!w_push_ok && w_pop) r_cnt <= r_cnt - 1'b1;
    end
  end

  // control registers and sticky flags; a new event beats a clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en     <= 1'b0;
      r_irq_en <= 1'b0;
      r_ovr    <= 1'b0;
      r_ferr   <= 1'b0;
      r_div    <= DIV_RESET;
      r_irq    <= 1'b0;
    end else begin
      if (w_wr_ctrl) begin
        r_en     <= dma_io_wdata[0];
        r_irq_en <= dma_io_wdata[1];
      end
      if (w_ovr_set)                        r_ovr <= 1'b1;
      else if (w_wr_ctrl && dma_io_wdata[2]) r_ovr <= 1'b0;
      if (w_ferr_set)                        r_ferr <= 1'b1;
      else if (w_wr_ctrl && dma_io_wdata[3]) r_ferr <= 1'b0;
      if (w_wr_div) r_div <= w_div_wr;
      r_irq <= w_push_ok & r_irq_en;
    end
  end

  assign w_roff = dma_io_radr - BASE_ADR;
  assign w_rsel = (w_roff[13:2] == 12'd0);
  assign w_cnt5 = 5'(r_cnt);

  // register read mux
  always_comb begin
    w_rval = 32'd0;
    unique case (w_roff[1:0])
      2'd0: w_rval = w_empty ? 32'd0 :
                     {23'd0, 1'b1, r_mem[r_rp]};
      2'd1: w_rval = {23'd0, w_cnt5, r_ferr, r_ovr,
                      w_full, ~w_empty};
      2'd2: w_rval = {30'd0, r_irq_en, r_en};
      2'd3: w_rval = {16'd0, r_div};
      default: w_rval = 32'd0;
    endcase
  end

  // registered read hit and data for the chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit   <= 1'b0;
      r_rdata <= 32'd0;
    end else begin
      r_hit   <= dma_io_radr_en & w_rsel;
      r_rdata <= w_rval;
    end
  end

  assign dma_io_rdata = r_hit ? r_rdata : dma_io_rdata_in;
  assign ext_uart_rx_interrupt_1shot = r_irq;

endmodule

// File: tb/tb_io_uart_in.sv
// tb_io_uart_in: random frames vs. queue model.
// Checks registers, FIFO order, flags and irq count.
module tb_io_uart_in;

  localparam logic [13:0] BASE = 14'h3F10;
  localparam logic [31:0] PASS = 32'hdeadbeef;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_in = 1'b1;
  logic        we = 1'b0;
  logic [13:0] wadr = '0;
  logic [31:0] wdata = '0;
  logic [13:0] radr = '0;
  logic        radr_en = 1'b0;
  logic [31:0] rdata_in = PASS;
  logic [31:0] rdata;
  logic        irq;

  always #5 clk = ~clk;

  io_uart_in dut (
    .clk                         (clk),
    .rst_n                       (rst_n),
    .rx_in                       (rx_in),
    .dma_io_we                   (we),
    .dma_io_wadr                 (wadr),
    .dma_io_wdata                (wdata),
    .dma_io_radr                 (radr),
    .dma_io_radr_en              (radr_en),
    .dma_io_rdata_in             (rdata_in),
    .dma_io_rdata                (rdata),
    .ext_uart_rx_interrupt_1shot (irq)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int irq_cnt = 0;
  int exp_irq = 0;

  logic [7:0] mq[$];
  bit m_ovr, m_ferr, m_en, m_ie;
  int div_cur = 434;

  always @(negedge clk) if (rst_n && irq) irq_cnt++;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h",
               tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_status();
    int n;
    n = mq.size();
    return {23'd0, 5'(n), m_ferr, m_ovr,
            n == 16, n != 0};
  endfunction

  task automatic bus_wr(input logic [13:0] a,
                        input logic [31:0] d);
    @(negedge clk);
    we = 1'b1; wadr = a; wdata = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic bus_rd(input logic [13:0] a,
                        output logic [31:0] d);
    @(negedge clk);
    radr = a; radr_en = 1'b1;
    @(negedge clk);
    radr_en = 1'b0;
    d = rdata;
  endtask

  task automatic wr_ctrl(input bit en, input bit ie,
                         input bit c_ovr, input bit c_ferr);
    bus_wr(BASE + 14'd2, {28'd0, c_ferr, c_ovr, ie, en});
    m_en = en; m_ie = ie;
    if (c_ovr) m_ovr = 0;
    if (c_ferr) m_ferr = 0;
  endtask

  task automatic rd_rx(input string tag);
    logic [31:0] d, e;
    bus_rd(BASE, d);
    if (mq.size() != 0) e = {23'd0, 1'b1, mq.pop_front()};
    else e = 32'd0;
    chk(tag, d, e);
  endtask

  task automatic rd_stat(input string tag);
    logic [31:0] d;
    bus_rd(BASE + 14'd1, d);
    chk(tag, d, m_status());
  endtask

  task automatic send_frame(input logic [7:0] b,
                            input bit stop, input int div);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      rx_in = bits[i];
      repeat (div) @(negedge clk);
    end
    rx_in = 1'b1;
  endtask

  task automatic model_frame(input logic [7:0] b,
                             input bit stop);
    if (!m_en) return;
    if (!stop) m_ferr = 1;
    else if (mq.size() < 16) begin
      mq.push_back(b);
      if (m_ie) exp_irq++;
    end else m_ovr = 1;
  endtask

  task automatic frame(input logic [7:0] b, input bit stop);
    send_frame(b, stop, div_cur);
    model_frame(b, stop);
  endtask

  task automatic set_div(input int d);
    bus_wr(BASE + 14'd3, 32'(d));
    div_cur = (d < 16) ? 16 : d;
  endtask

  logic [31:0] d;
  int nr;
  bit st;
  logic [7:0] rb;

  initial begin
    repeat (3) @(negedge clk);
    chk("irq_in_reset", {31'd0, irq}, 32'd0);
    chk("pass_in_reset", rdata, PASS);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    bus_rd(BASE + 14'd1, d); chk("rst_status", d, 32'd0);
    bus_rd(BASE + 14'd2, d); chk("rst_ctrl", d, 32'd0);
    bus_rd(BASE + 14'd3, d); chk("rst_div", d, 32'd434);
    bus_rd(BASE + 14'd5, d); chk("miss_hi", d, PASS);
    bus_rd(BASE - 14'd1, d); chk("miss_lo", d, PASS);
    bus_rd(BASE, d); chk("rst_rx_empty", d, 32'd0);

    wr_ctrl(1, 1, 0, 0);
    bus_rd(BASE + 14'd2, d); chk("ctrl_rb", d, 32'd3);
    set_div(5);
    bus_rd(BASE + 14'd3, d); chk("div_clamp5", d, 32'd16);
    set_div(16);
    bus_rd(BASE + 14'd3, d); chk("div16", d, 32'd16);

    frame(8'hA5, 1);
    chk("irq_a5", irq_cnt, exp_irq);
    chk("irq_a5_one", irq_cnt, 32'd1);
    rd_stat("stat_a5");
    rd_rx("rx_a5");
    rd_rx("rx_a5_empty");

    for (int i = 0; i <= 16; i++) frame(8'(i), 1);
    rd_stat("stat_full_ovr");
    chk("irq_after_fill", irq_cnt, exp_irq);
    for (int i = 0; i < 16; i++) rd_rx("rx_fill_order");
    wr_ctrl(1, 1, 1, 0);
    rd_stat("stat_ovr_clr");
    bus_rd(BASE + 14'd2, d); chk("ctrl_rb_clr", d, 32'd3);

    frame(8'h3C, 0);
    rd_stat("stat_ferr");
    chk("irq_ferr", irq_cnt, exp_irq);
    wr_ctrl(1, 1, 0, 1);

    @(negedge clk); rx_in = 1'b0;
    repeat (4) @(negedge clk); rx_in = 1'b1;
    repeat (48) @(negedge clk);
    rd_stat("stat_glitch");
    chk("irq_glitch", irq_cnt, exp_irq);

    fork
      send_frame(8'h77, 1, div_cur);
      begin
        repeat (80) @(negedge clk);
        wr_ctrl(0, 1, 0, 0);
      end
    join
    model_frame(8'h77, 1);
    rd_stat("stat_en_abort");
    chk("irq_en_abort", irq_cnt, exp_irq);
    wr_ctrl(1, 1, 0, 0);
    frame(8'h55, 1);
    rd_rx("rx_55");

    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 3) == 0)
        set_div(16 + 2 * $urandom_range(0, 4));
      if ($urandom_range(0, 5) == 0)
        wr_ctrl(1, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)));
      rb = 8'($urandom);
      st = ($urandom_range(0, 7) != 0);
      frame(rb, st);
      nr = $urandom_range(0, 2);
      for (int k = 0; k < nr; k++) rd_rx("rx_rand");
      if ($urandom_range(0, 1) == 0) rd_stat("stat_rand");
    end
    chk("irq_rand", irq_cnt, exp_irq);

    set_div(16);
    wr_ctrl(1, 1, 1, 1);
    while (mq.size() != 0) rd_rx("rx_drain");
    for (int i = 0; i < 16; i++) frame(8'(8'hC0 + i), 1);
    rd_stat("stat_full16");
    fork
      send_frame(8'hEE, 1, 16);
      begin
        @(negedge clk);
        repeat (154) @(negedge clk);
        rd_rx("rx_pop_at_push");
      end
    join
    model_frame(8'hEE, 1);
    rd_stat("stat_pop_push");
    chk("irq_pop_push", irq_cnt, exp_irq);

    fork
      send_frame(8'h99, 1, 16);
      begin
        repeat (70) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
      end
    join
    mq.delete();
    m_ovr = 0; m_ferr = 0; m_en = 0; m_ie = 0;
    repeat (4) @(negedge clk);
    rd_stat("stat_midrst");
    bus_rd(BASE + 14'd2, d); chk("ctrl_midrst", d, 32'd0);
    bus_rd(BASE + 14'd3, d); chk("div_midrst", d, 32'd434);
    bus_rd(BASE, d); chk("rx_midrst", d, 32'd0);
    chk("irq_final", irq_cnt, exp_irq);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
